// File: rtl/gamesys_collide.sv
// gamesys_collide: player/wall and player/boundary collision detector and
// game-state FSM (IDLE, RUN, HIT, OVER) sitting between physics and render/UI.
// Drives the physics pause/reset inputs and keeps the best score seen.
// Optional build macro GAMESYS_COLLIDE_GODMODE_EN: when defined, god_mode=1
// masks wall hits (boundary hits still end the run); otherwise god_mode is ignored.
module gamesys_collide #(
    parameter int POS_W       = 13,
    parameter int N_WALLS     = 5,
    parameter int PLAYER_HALF = 12,
    parameter int WALL_HALF_W = 30,
    parameter int FLOOR_Y     = 480,
    parameter int CEIL_Y      = 0,
    parameter int HIT_HOLD    = 30
) (
    input  logic                       game_clk,
    input  logic                       reset,
    input  logic                       btn_jmp,
    input  logic signed [POS_W-1:0]    pos_player_x,
    input  logic signed [POS_W-1:0]    pos_player_y,
    input  logic [N_WALLS*POS_W-1:0]   pos_wall_x,
    input  logic [N_WALLS*POS_W-1:0]   pos_wall_y,
    input  logic [N_WALLS*POS_W-1:0]   pos_wall_height,
    input  logic [15:0]                score,
    input  logic                       god_mode,
    output logic                       phy_pause,
    output logic                       phy_reset,
    output logic                       game_over,
    output logic                       hit,
    output logic [15:0]                best_score,
    output logic [1:0]                 state
);

    localparam int W      = POS_W + 2;
    localparam int IDX_W  = (N_WALLS > 1) ? $clog2(N_WALLS) : 1;
    localparam int HOLD_W = $clog2(HIT_HOLD + 1);
    localparam int PW     = N_WALLS * POS_W;

    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(N_WALLS - 1);
    localparam logic [HOLD_W-1:0]   LAST_HOLD = HOLD_W'(HIT_HOLD - 1);
    localparam logic signed [W-1:0] X_REACH   = W'(WALL_HALF_W + PLAYER_HALF);
    localparam logic signed [W-1:0] P_HALF    = W'(PLAYER_HALF);
    localparam logic signed [W-1:0] FLOOR     = W'(FLOOR_Y);
    localparam logic signed [W-1:0] CEIL      = W'(CEIL_Y);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 btn_old_q;
    logic                 phy_reset_q, phy_reset_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     ev_idx_q, ev_idx_d;
    logic                 ev_vld_q, ev_vld_d;
    logic                 acc_q, acc_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 over_first_q, over_first_d;
    logic [15:0]          best_q, best_d;
    logic [POS_W-1:0]     snap_px_q, snap_px_d;
    logic [POS_W-1:0]     snap_py_q, snap_py_d;
    logic [PW-1:0]        snap_wx_q, snap_wx_d;
    logic [PW-1:0]        snap_wy_q, snap_wy_d;
    logic [PW-1:0]        snap_wh_q, snap_wh_d;

    logic                 start_evt;
    logic                 wall_hit;
    logic                 bnd_hit;
    logic                 acc_now;

    logic signed [W-1:0]  px, py, wx, wy, wh;
    logic signed [W-1:0]  dx, adx, half, gap_lo, gap_hi;

    function automatic logic signed [W-1:0] sx(input logic [POS_W-1:0] v);
        return {{2{v[POS_W-1]}}, v};
    endfunction

    // Evaluate the wall selected by the evaluation index against the snapshot.
    always_comb begin
        px     = sx(snap_px_q);
        py     = sx(snap_py_q);
        wx     = sx(snap_wx_q[int'(ev_idx_q)*POS_W +: POS_W]);
        wy     = sx(snap_wy_q[int'(ev_idx_q)*POS_W +: POS_W]);
        wh     = sx(snap_wh_q[int'(ev_idx_q)*POS_W +: POS_W]);
        dx     = px - wx;
        adx    = (dx < 0) ? -dx : dx;
        half   = wh >>> 1;
        gap_lo = wy - half;
        gap_hi = wy + half;
        wall_hit = (adx < X_REACH) && ((py - P_HALF < gap_lo) || (py + P_HALF > gap_hi));
`ifdef GAMESYS_COLLIDE_GODMODE_EN
        if (god_mode) begin
            wall_hit = 1'b0;
        end
`endif
        bnd_hit = (py + P_HALF > FLOOR) || (py - P_HALF < CEIL);
        acc_now = wall_hit
                | ((ev_idx_q == '0) ? bnd_hit : acc_q);
    end

`ifndef GAMESYS_COLLIDE_GODMODE_EN
    logic unused_god_mode;
    assign unused_god_mode = god_mode;
`endif

    // Next-state, scan sequencing, hold counter and best-score update.
    // The scan is a two-stage pipeline: idx_q snapshots at 0 while ev_idx_q
    // evaluates one cycle behind, so the wrap decision lands N_WALLS+1 cycles
    // after the snapshot.
    always_comb begin
        state_d      = state_q;
        phy_reset_d  = 1'b0;
        idx_d        = '0;
        ev_idx_d     = '0;
        ev_vld_d     = 1'b0;
        acc_d        = 1'b0;
        hold_d       = '0;
        over_first_d = 1'b0;
        best_d       = best_q;
        snap_px_d    = snap_px_q;
        snap_py_d    = snap_py_q;
        snap_wx_d    = snap_wx_q;
        snap_wy_d    = snap_wy_q;
        snap_wh_d    = snap_wh_q;
        start_evt    = btn_jmp && !btn_old_q;

        case (state_q)
            ST_IDLE: begin
                if (phy_reset_q) begin
                    state_d = ST_RUN;
                end else if (start_evt) begin
                    phy_reset_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (ev_vld_q && (ev_idx_q == LAST_IDX) && acc_now) begin
                    state_d = ST_HIT;
                end
            end
            ST_HIT: begin
                if (hold_q == LAST_HOLD) begin
                    state_d      = ST_OVER;
                    over_first_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_OVER: begin
                if (over_first_q && (score > best_q)) begin
                    best_d = score;
                end
                if (phy_reset_q) begin
                    state_d = ST_IDLE;
                end else if (start_evt) begin
                    phy_reset_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_RUN && idx_q == '0) begin
            snap_px_d = pos_player_x;
            snap_py_d = pos_player_y;
            snap_wx_d = pos_wall_x;
            snap_wy_d = pos_wall_y;
            snap_wh_d = pos_wall_height;
        end

        if (state_q == ST_RUN && state_d == ST_RUN) begin
            idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            ev_idx_d = idx_q;
            ev_vld_d = 1'b1;
            acc_d    = ev_vld_q ? acc_now : 1'b0;
        end
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge game_clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            btn_old_q    <= 1'b0;
            phy_reset_q  <= 1'b0;
            idx_q        <= '0;
            ev_idx_q     <= '0;
            ev_vld_q     <= 1'b0;
            acc_q        <= 1'b0;
            hold_q       <= '0;
            over_first_q <= 1'b0;
            best_q       <= '0;
            snap_px_q    <= '0;
            snap_py_q    <= '0;
            snap_wx_q    <= '0;
            snap_wy_q    <= '0;
            snap_wh_q    <= '0;
        end else begin
            state_q      <= state_d;
            btn_old_q    <= btn_jmp;
            phy_reset_q  <= phy_reset_d;
            idx_q        <= idx_d;
            ev_idx_q     <= ev_idx_d;
            ev_vld_q     <= ev_vld_d;
            acc_q        <= acc_d;
            hold_q       <= hold_d;
            over_first_q <= over_first_d;
            best_q       <= best_d;
            snap_px_q    <= snap_px_d;
            snap_py_q    <= snap_py_d;
            snap_wx_q    <= snap_wx_d;
            snap_wy_q    <= snap_wy_d;
            snap_wh_q    <= snap_wh_d;
        end
    end

    // Outputs decode directly from the registered state.
    always_comb begin
        phy_pause  = (state_q != ST_RUN);
        hit        = (state_q == ST_HIT);
        game_over  = (state_q == ST_OVER);
        phy_reset  = phy_reset_q;
        best_score = best_q;
        state      = state_q;
    end

endmodule
